alu_md_sequencer: RTL and testbench

- Multi-cycle RV32M multiply/divide unit (MUL, DIVU, REMU) that drives the shared combinational ALU: it owns the ALU control, SrcA and SrcB inputs and consumes the ALU result and zero flag.
- Sits beside the execute stage.
- Accepts one operation through a valid/ready handshake, iterates shift-add or restoring division through the ALU, and returns a 32-bit result through a valid/ready handshake.

---
 rtl/alu_md_sequencer.sv | 149 ++++++++++++++
 tb/tb_alu_md_sequencer.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/alu_md_sequencer.sv
// Multi-cycle RV32M MUL/DIVU/REMU sequencer that borrows the shared combinational ALU.
// Shift-add multiply, restoring divide, one operation in flight, valid/ready on both sides.
module alu_md_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      in_op,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [3:0]      alu_control,
  output logic [XLEN-1:0] alu_src_a,
  output logic [XLEN-1:0] alu_src_b,
  input  logic [XLEN-1:0] alu_result,
  input  logic            alu_zero
);

  typedef enum logic [2:0] {IDLE, MUL_STEP, DIV_CMP, DIV_SUB, DONE} state_t;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [4:0] LAST     = 5'(XLEN - 1);

  state_t          state, state_nxt;
  logic [4:0]      cnt;
  logic [XLEN-1:0] acc, mcand, mplier;
  logic [XLEN-1:0] rem, quo, dvs;
  logic [XLEN-1:0] result;
  logic            lt, is_rem;
  logic [XLEN-1:0] sh;
  logic            last;

  assign sh         = {rem[XLEN-2:0], quo[XLEN-1]};
  assign last       = (cnt == LAST);
  assign in_ready   = (state == IDLE);
  assign out_valid  = (state == DONE);
  assign out_result = result;

  always_comb begin
    state_nxt   = state;
    alu_control = ALU_ADD;
    alu_src_a   = '0;
    alu_src_b   = '0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          case (in_op)
            2'b00:        state_nxt = MUL_STEP;
            2'b01, 2'b10: state_nxt = (in_b == '0) ? DONE : DIV_CMP;
            default:      state_nxt = DONE;
          endcase
        end
      end
      MUL_STEP: begin
        alu_control = ALU_ADD;
        alu_src_a   = acc;
        alu_src_b   = mcand;
        if (last) state_nxt = DONE;
      end
      DIV_CMP: begin
        alu_control = ALU_SLTU;
        alu_src_a   = sh;
        alu_src_b   = dvs;
        state_nxt   = DIV_SUB;
      end
      DIV_SUB: begin
        alu_control = ALU_SUB;
        alu_src_a   = rem;
        alu_src_b   = dvs;
        state_nxt   = last ? DONE : DIV_CMP;
      end
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The shifted-out dividend bit (rem[MSB]) makes the partial remainder 33 bits wide,
  // which can never be below the divisor, so it forces a subtract.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      rem    <= '0;
      quo    <= '0;
      dvs    <= '0;
      result <= '0;
      lt     <= 1'b0;
      is_rem <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (in_valid) begin
            cnt    <= '0;
            acc    <= '0;
            mcand  <= in_a;
            mplier <= in_b;
            rem    <= '0;
            quo    <= in_a;
            dvs    <= in_b;
            lt     <= 1'b0;
            is_rem <= (in_op == 2'b10);
            case (in_op)
              2'b01:   result <= '1;
              2'b10:   result <= in_a;
              default: result <= '0;
            endcase
          end
        end
        MUL_STEP: begin
          if (mplier[0]) acc <= alu_result;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 5'd1;
          if (last) result <= mplier[0] ? alu_result : acc;
        end
        DIV_CMP: begin
          rem <= sh;
          quo <= quo << 1;
          lt  <= !alu_zero && !rem[XLEN-1];
        end
        DIV_SUB: begin
          if (!lt) begin
            rem    <= alu_result;
            quo[0] <= 1'b1;
          end
          cnt <= cnt + 5'd1;
          if (last) begin
            if (is_rem) result <= lt ? rem : alu_result;
            else        result <= {quo[XLEN-1:1], !lt};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_md_sequencer.sv
// Bench for alu_md_sequencer: models the shared ALU, drives directed operations and
// checks results, latency, handshakes and ALU-bus behaviour against a reference model.
module tb_alu_md_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [31:0] in_a, in_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [3:0]  alu_control;
  logic [31:0] alu_src_a, alu_src_b;
  logic [31:0] alu_result;
  logic        alu_zero;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic        tb_busy  = 1'b0;
  logic [1:0]  exp_op   = 2'b00;
  logic [31:0] exp_res  = '0;

  alu_md_sequencer #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .alu_control(alu_control), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_result(alu_result), .alu_zero(alu_zero)
  );

  always #5 clk = ~clk;

  // Shared execute-stage ALU, reduced to the three operations the sequencer uses.
  always_comb begin
    case (alu_control)
      4'b0000: alu_result = alu_src_a + alu_src_b;
      4'b1000: alu_result = alu_src_a - alu_src_b;
      4'b0011: alu_result = {31'b0, alu_src_a < alu_src_b};
      default: alu_result = 32'h0;
    endcase
    alu_zero = (alu_result == 32'h0);
  end

  function automatic logic [31:0] refModel(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = 64'(a) * 64'(b);
    case (op)
      2'b00:   return p[31:0];
      2'b01:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      2'b10:   return (b == 0) ? a : a % b;
      default: return 32'h0;
    endcase
  endfunction

  function automatic int refLatency(input logic [1:0] op, input logic [31:0] b);
    if (op == 2'b00) return 33;
    if (op == 2'b11 || b == 0) return 1;
    return 65;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model while a transaction is outstanding.
  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("ready_valid_exclusive", 32'(in_ready && out_valid), 32'h0);
      if (in_ready || out_valid)
        checkOutput("alu_bus_quiet", {28'b0, alu_control} | alu_src_a | alu_src_b, 32'h0);
      if (tb_busy && out_valid)
        checkOutput("result_stable", out_result, exp_res);
      if (tb_busy && !out_valid && !in_ready) begin
        if (exp_op == 2'b00)
          checkOutput("mul_alu_add", 32'(alu_control), 32'h0);
        else
          checkOutput("div_alu_op", 32'(alu_control == 4'b1000 || alu_control == 4'b0011), 32'h1);
      end
    end
  end

  task automatic applyStimulus(input string name, input logic [1:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] lit, input int hold);
    int cycles;
    @(negedge clk); #2;
    checkOutput({name, "_in_ready"}, 32'(in_ready), 32'h1);
    exp_res = refModel(op, a, b);
    exp_op  = op;
    checkOutput({name, "_model_pin"}, exp_res, lit);
    in_valid  = 1'b1;
    in_op     = op;
    in_a      = a;
    in_b      = b;
    out_ready = (hold == 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_a     = 32'hDEAD_BEEF;
    in_b     = 32'hDEAD_BEEF;
    tb_busy  = 1'b1;
    cycles   = 1;
    while (!out_valid && cycles < 200) begin
      @(posedge clk); #1;
      cycles++;
    end
    checkOutput({name, "_latency"}, 32'(cycles), 32'(refLatency(op, b)));
    checkOutput({name, "_result"}, out_result, exp_res);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      in_op    = 2'b00;
      in_a     = 32'h5;
      in_b     = 32'h5;
      @(posedge clk); #1;
      checkOutput({name, "_hold_valid"}, 32'(out_valid), 32'h1);
      checkOutput({name, "_hold_result"}, out_result, exp_res);
      checkOutput({name, "_hold_in_ready"}, 32'(in_ready), 32'h0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput({name, "_ret_valid"}, 32'(out_valid), 32'h0);
    checkOutput({name, "_ret_in_ready"}, 32'(in_ready), 32'h1);
    tb_busy   = 1'b0;
    out_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_op = 2'b00; in_a = '0; in_b = '0; out_ready = 1'b0;
    #1;
    checkOutput("rst_in_ready", 32'(in_ready), 32'h1);
    checkOutput("rst_out_valid", 32'(out_valid), 32'h0);
    checkOutput("rst_out_result", out_result, 32'h0);
    checkOutput("rst_alu_bus", {28'b0, alu_control} | alu_src_a | alu_src_b, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    applyStimulus("mul_1234x10", 2'b00, 32'h0000_1234, 32'h0000_0010, 32'h0001_2340, 0);
    applyStimulus("mul_wrap", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 0);
    applyStimulus("divu_100_7", 2'b01, 32'd100, 32'd7, 32'd14, 0);
    applyStimulus("remu_100_7", 2'b10, 32'd100, 32'd7, 32'd2, 0);
    applyStimulus("divu_c1", 2'b01, 32'hFFFF_FFFF, 32'h8000_0001, 32'h0000_0001, 0);
    applyStimulus("remu_c1", 2'b10, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, 0);
    applyStimulus("divu_small", 2'b01, 32'd7, 32'd100, 32'd0, 0);
    applyStimulus("remu_small", 2'b10, 32'd7, 32'd100, 32'd7, 0);
    applyStimulus("divu_by0", 2'b01, 32'd5, 32'd0, 32'hFFFF_FFFF, 0);
    applyStimulus("remu_by0", 2'b10, 32'd5, 32'd0, 32'd5, 0);
    applyStimulus("reserved", 2'b11, 32'd9, 32'd3, 32'd0, 0);
    applyStimulus("mul_backpressure", 2'b00, 32'd3, 32'd4, 32'd12, 10);

    // Abort a divide with an asynchronous reset between clock edges.
    @(negedge clk); #2;
    in_valid = 1'b1; in_op = 2'b01; in_a = 32'd1000; in_b = 32'd3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    exp_op   = 2'b01;
    exp_res  = refModel(2'b01, 32'd1000, 32'd3);
    tb_busy  = 1'b1;
    repeat (19) @(posedge clk);
    @(negedge clk); #2;
    tb_busy = 1'b0;
    rst_n   = 1'b0;
    #1;
    checkOutput("arst_out_valid", 32'(out_valid), 32'h0);
    checkOutput("arst_in_ready", 32'(in_ready), 32'h1);
    checkOutput("arst_out_result", out_result, 32'h0);
    checkOutput("arst_alu_bus", {28'b0, alu_control} | alu_src_a | alu_src_b, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus("mul_after_reset", 2'b00, 32'd6, 32'd7, 32'd42, 0);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
